pm_loader: RTL and testbench
============================

# pm_loader

Boot-time program loader placed directly upstream of the 8-bit microprocessor's program memory. It accepts a framed byte stream (header, length, payload, checksum), writes the payload into program memory starting at address 0, and holds the processor in reset until a complete frame with a valid checksum has been written. It can reload at any time: a new header byte re-asserts processor reset and starts a fresh load.

## Interface
- TIMEOUT_CYCLES, 1000: maximum idle cycles between bytes inside a frame before the load is aborted.
- HEADER, 8'hA5: frame start byte.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_valid  input  1  rx_data holds a byte this cycle.
- rx_data  input  8  incoming byte.
- rx_ready  output  1  loader can accept a byte. A byte transfers on a cycle with rx_valid & rx_ready.
- pm_wr_addr  output  8  program-memory write address.
- pm_wr_data  output  8  program-memory write data.
- pm_wren  output  1  one-cycle write strobe.
- cpu_reset  output  1  drives the processor's reset input; high while no valid program is loaded.
- load_done  output  1  last frame loaded and checksum matched.
- load_error  output  1  last frame failed (checksum mismatch or timeout).
- byte_count  output  9  payload bytes written in the current or last frame (0..256).

## Operation
- States: IDLE, LEN, DATA, CHK, DONE, ERROR.
- IDLE: a transferred byte equal to HEADER moves to LEN. Any other byte is discarded.
- LEN: the transferred byte sets the payload length N. A value of 0 means 256. Then:
  - clear byte_count, the checksum accumulator and the address counter;
  - move to DATA.
- DATA: each transferred byte is written to pm_wr_addr = address counter. Then:
  - checksum accumulator += byte (mod 256), the address counter increments, byte_count increments;
  - after the Nth byte, move to CHK.
- CHK: a transferred byte equal to the accumulator goes to DONE; otherwise it goes to ERROR.
- DONE: load_done=1, cpu_reset=0. A HEADER byte goes to LEN; other bytes are ignored.
- ERROR: load_error=1, cpu_reset=1. A HEADER byte goes to LEN; other bytes are ignored.
- Entering LEN from any state clears load_done and load_error and sets cpu_reset=1.
- Timeout:
  - An idle counter runs in LEN, DATA and CHK. It clears on each transfer and increments on every other cycle.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to ERROR.
- The address counter is 8 bits. With N=256 the last write is address 255, and the counter wraps to 0 unused.
- Memory contents beyond N are left unchanged.
- rx_ready is 1 in every state while out of reset. No backpressure is needed because each byte completes in one cycle.
- A HEADER-valued byte inside DATA or CHK is treated as data or checksum, not as a restart.

## Timing
- Reset values:
  - state=IDLE, rx_ready=0, pm_wren=0, pm_wr_addr=0, pm_wr_data=0;
  - cpu_reset=1, load_done=0, load_error=0, byte_count=0;
  - idle counter=0, accumulator=0.
- rx_ready rises on the first clk edge after reset deasserts.
- All outputs are registered.
- Write timing: a data byte transferred at edge k produces pm_wren=1 with the matching pm_wr_addr and pm_wr_data during cycle k+1 (after edge k). pm_wren is otherwise 0.
- Back-to-back transfers give back-to-back write strobes, one per cycle.
- Checksum accept at edge k: load_done=1 and cpu_reset=0 after edge k+1. This one extra cycle guarantees the final write has landed before the processor leaves reset.
- Header at edge k while in DONE: cpu_reset=1 after edge k.
- Mismatch or timeout at edge k: load_error=1 after edge k.
- Reset asserted mid-frame: the partial write sequence stops immediately (pm_wren=0), cpu_reset=1, and the FSM returns to IDLE. Memory already written is not cleared.
- Timeout boundary: a byte arriving in the same cycle the counter reaches TIMEOUT_CYCLES is accepted, and the timeout does not fire.

## Test plan
- Frame A5,03,11,22,33,66 sent on consecutive cycles -> writes (0,11),(1,22),(2,33) on three consecutive pm_wren cycles; byte_count=3; load_done=1; cpu_reset=0 one cycle after the checksum transfer.
- Same frame with checksum 67 -> no done; load_error=1; cpu_reset stays 1. Then the good frame is sent -> load_done=1, load_error=0.
- Length byte 00 followed by 256 bytes of value i, then checksum 80 -> writes to addresses 0..255; byte_count=256; load_done=1.
- A5,02,10 then rx_valid held low for TIMEOUT_CYCLES -> ERROR, load_error=1, only address 0 written. A byte at exactly the limit cycle is accepted instead.
- After DONE, send 5A then A5 -> 5A ignored with cpu_reset still 0; A5 sets cpu_reset=1 and clears load_done.
- reset pulsed mid-DATA (after 2 of 4 bytes) -> pm_wren=0 immediately, cpu_reset=1, state IDLE. The next full frame loads correctly from address 0.

Source files
------------

// File: rtl/pm_loader.sv
// Boot-time program loader: takes a framed byte stream (header, length, payload, checksum),
// writes the payload to program memory from address 0 and gates the processor reset.
module pm_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [7:0]  HEADER         = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       rx_ready,
  output logic [7:0] pm_wr_addr,
  output logic [7:0] pm_wr_data,
  output logic       pm_wren,
  output logic       cpu_reset,
  output logic       load_done,
  output logic       load_error,
  output logic [8:0] byte_count
);

  localparam int unsigned      IdleW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StError
  } state_e;

  state_e           state_q, state_d;
  logic [IdleW-1:0] idle_q, idle_d;
  logic [8:0]       len_q, len_d;
  logic [8:0]       count_q, count_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       sum_q, sum_d;
  logic [7:0]       wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             ready_q;
  logic             wren_q, wren_d;
  logic             cpu_reset_q, cpu_reset_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             pend_q, pend_d;

  logic xfer;
  logic is_header;
  logic start;
  logic idle_tick;

  assign xfer      = rx_valid & ready_q;
  assign is_header = (rx_data == HEADER);

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    len_d       = len_q;
    count_d     = count_q;
    addr_d      = addr_q;
    sum_d       = sum_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wren_d      = 1'b0;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;
    pend_d      = pend_q;
    start       = 1'b0;
    idle_tick   = 1'b0;

    unique case (state_q)
      StIdle: start = xfer & is_header;
      StLen: begin
        if (xfer) begin
          len_d   = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          count_d = '0;
          sum_d   = '0;
          addr_d  = '0;
          idle_d  = '0;
          state_d = StData;
        end else begin
          idle_tick = 1'b1;
        end
      end
      StData: begin
        if (xfer) begin
          wren_d    = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          sum_d     = sum_q + rx_data;
          addr_d    = addr_q + 8'd1;
          count_d   = count_q + 9'd1;
          idle_d    = '0;
          if (count_q + 9'd1 == len_q) begin
            state_d = StChk;
          end
        end else begin
          idle_tick = 1'b1;
        end
      end
      StChk: begin
        if (xfer) begin
          idle_d = '0;
          if (rx_data == sum_q) begin
            // Release is deferred one cycle so the final write lands first.
            state_d = StDone;
            pend_d  = 1'b1;
          end else begin
            state_d     = StError;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end else begin
          idle_tick = 1'b1;
        end
      end
      StDone: begin
        if (pend_q) begin
          done_d      = 1'b1;
          cpu_reset_d = 1'b0;
          pend_d      = 1'b0;
        end
        start = xfer & is_header;
      end
      StError: start = xfer & is_header;
      default: state_d = StIdle;
    endcase

    if (idle_tick) begin
      if (idle_q == IdleLast) begin
        state_d     = StError;
        error_d     = 1'b1;
        cpu_reset_d = 1'b1;
        idle_d      = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end

    // A header outside a frame restarts the load and overrides any pending release.
    if (start) begin
      state_d     = StLen;
      done_d      = 1'b0;
      error_d     = 1'b0;
      cpu_reset_d = 1'b1;
      pend_d      = 1'b0;
      idle_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idle_q      <= '0;
      len_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      sum_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      ready_q     <= 1'b0;
      wren_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      len_q       <= len_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      sum_q       <= sum_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ready_q     <= 1'b1;
      wren_q      <= wren_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
      pend_q      <= pend_d;
    end
  end

  assign rx_ready   = ready_q;
  assign pm_wr_addr = wr_addr_q;
  assign pm_wr_data = wr_data_q;
  assign pm_wren    = wren_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = done_q;
  assign load_error = error_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: a frame-level reference model compared every cycle, directed frames
// with literal expectations, then randomized frames, junk, bad checksums and reset pulses.
module tb_pm_loader;
  localparam int unsigned To  = 1000;
  localparam logic [7:0]  Hdr = 8'hA5;

  logic       clk      = 1'b0;
  logic       reset    = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_ready, pm_wren, cpu_reset, load_done, load_error;
  logic [7:0] pm_wr_addr, pm_wr_data;
  logic [8:0] byte_count;

  pm_loader #(.TIMEOUT_CYCLES(To), .HEADER(Hdr)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .pm_wr_addr(pm_wr_addr),
    .pm_wr_data(pm_wr_data),
    .pm_wren   (pm_wren),
    .cpu_reset (cpu_reset),
    .load_done (load_done),
    .load_error(load_error),
    .byte_count(byte_count)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: frame bytes after the header are kept in a queue and every
  // output is derived from the queue contents.
  bit         m_ready, m_active, m_pend;
  bit         e_wren, e_done, e_err, e_cpu;
  int         e_addr, e_data, e_count, gap;
  int         fq[$];
  logic [7:0] exp_mem[256];
  logic [7:0] dut_mem[256];
  int         wlog_addr[$], wlog_data[$], wlog_cyc[$];
  int         cyc = 0;
  int         sq[$];

  task automatic model_reset();
    m_ready = 0; m_active = 0; m_pend = 0;
    e_wren = 0; e_done = 0; e_err = 0; e_cpu = 1;
    e_addr = 0; e_data = 0; e_count = 0; gap = 0;
    fq.delete();
  endtask

  task automatic model_step();
    bit xfer;
    int b, n, len, s;
    xfer    = rx_valid && m_ready;
    b       = int'(rx_data);
    e_wren  = 0;
    m_ready = 1;
    if (m_pend) begin
      e_done = 1; e_cpu = 0; m_pend = 0;
    end
    if (!m_active) begin
      if (xfer && rx_data == Hdr) begin
        m_active = 1; fq.delete();
        e_done = 0; e_err = 0; e_cpu = 1; m_pend = 0; gap = 0;
      end
    end else if (xfer) begin
      gap = 0;
      fq.push_back(b);
      n = fq.size();
      if (n == 1) begin
        e_count = 0;
      end else begin
        len = (fq[0] == 0) ? 256 : fq[0];
        if (n - 1 <= len) begin
          e_wren = 1; e_addr = n - 2; e_data = b; e_count = n - 1;
          exp_mem[8'(n - 2)] = rx_data;
        end else begin
          s = 0;
          for (int i = 1; i <= len; i++) s += fq[i];
          if (b == s % 256) m_pend = 1;
          else e_err = 1;
          m_active = 0;
        end
      end
    end else begin
      gap++;
      if (gap == To) begin
        e_err = 1; m_active = 0; gap = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    chk("rx_ready", int'(rx_ready), int'(m_ready));
    chk("pm_wren", int'(pm_wren), int'(e_wren));
    chk("pm_wr_addr", int'(pm_wr_addr), e_addr);
    chk("pm_wr_data", int'(pm_wr_data), e_data);
    chk("cpu_reset", int'(cpu_reset), int'(e_cpu));
    chk("load_done", int'(load_done), int'(e_done));
    chk("load_error", int'(load_error), int'(e_err));
    chk("byte_count", int'(byte_count), e_count);
    if (pm_wren) begin
      dut_mem[pm_wr_addr] = pm_wr_data;
      wlog_addr.push_back(int'(pm_wr_addr));
      wlog_data.push_back(int'(pm_wr_data));
      wlog_cyc.push_back(cyc);
    end
  end

  // Drives sq one byte per transfer, with up to gap_max idle cycles before each byte.
  task automatic send(input int gap_max);
    int g;
    foreach (sq[i]) begin
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'(sq[i]);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_mem(input string name);
    int nm;
    nm = 0;
    for (int i = 0; i < 256; i++) if (dut_mem[8'(i)] != exp_mem[8'(i)]) nm++;
    chk(name, nm, 0);
  endtask

  task automatic rand_frame();
    int kind, len, s, nj, keep, gm;
    logic [7:0] b;
    kind = int'($urandom_range(0, 9));
    gm   = int'($urandom_range(0, 2));
    nj   = int'($urandom_range(0, 2));
    sq   = {};
    for (int j = 0; j < nj; j++) begin
      b = 8'($urandom_range(0, 255));
      if (b == Hdr) b = 8'h5A;
      sq.push_back(int'(b));
    end
    len = ($urandom_range(0, 15) == 0) ? 256 : int'($urandom_range(1, 24));
    sq.push_back(int'(Hdr));
    sq.push_back(len % 256);
    s = 0;
    for (int j = 0; j < len; j++) begin
      b = 8'($urandom_range(0, 255));
      s += int'(b);
      sq.push_back(int'(b));
    end
    if (kind >= 6 && kind <= 7) sq.push_back((s + 1 + int'($urandom_range(0, 254))) % 256);
    else sq.push_back(s % 256);
    if (kind == 8) begin
      keep = int'($urandom_range(nj + 1, sq.size() - 1));
      while (sq.size() > keep) void'(sq.pop_back());
      send(gm);
      #3 reset = 1'b1;
      @(negedge clk);
      #3 reset = 1'b0;
    end else begin
      send(gm);
    end
  endtask

  int t1d[3] = '{'h11, 'h22, 'h33};
  int w0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      exp_mem[8'(i)] = 8'h00;
      dut_mem[8'(i)] = 8'h00;
    end

    // Reset values
    #1 reset = 1'b1;
    #2;
    chk("rst_rx_ready", int'(rx_ready), 0);
    chk("rst_pm_wren", int'(pm_wren), 0);
    chk("rst_pm_wr_addr", int'(pm_wr_addr), 0);
    chk("rst_pm_wr_data", int'(pm_wr_data), 0);
    chk("rst_cpu_reset", int'(cpu_reset), 1);
    chk("rst_load_done", int'(load_done), 0);
    chk("rst_load_error", int'(load_error), 0);
    chk("rst_byte_count", int'(byte_count), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(rx_ready), 1);

    // Good 3-byte frame on consecutive cycles
    w0 = wlog_addr.size();
    sq = '{'hA5, 'h03, 'h11, 'h22, 'h33, 'h66};
    send(0);
    chk("t1_cpu_reset_hold", int'(cpu_reset), 1);
    chk("t1_done_not_yet", int'(load_done), 0);
    @(negedge clk);
    chk("t1_load_done", int'(load_done), 1);
    chk("t1_cpu_reset", int'(cpu_reset), 0);
    chk("t1_byte_count", int'(byte_count), 3);
    chk("t1_nwrites", wlog_addr.size() - w0, 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1_addr", wlog_addr[w0 + i], i);
      chk("t1_data", wlog_data[w0 + i], t1d[i]);
    end
    chk("t1_back_to_back", wlog_cyc[w0 + 2] - wlog_cyc[w0], 2);

    // Junk ignored in DONE, header restarts, then a bad checksum, then a good frame
    sq = '{'h5A};
    send(0);
    chk("t2_junk_cpu_reset", int'(cpu_reset), 0);
    chk("t2_junk_done", int'(load_done), 1);
    sq = '{'hA5};
    send(0);
    chk("t2_hdr_cpu_reset", int'(cpu_reset), 1);
    chk("t2_hdr_done", int'(load_done), 0);
    sq = '{'h03, 'h11, 'h22, 'h33, 'h67};
    send(0);
    chk("t2_bad_error", int'(load_error), 1);
    chk("t2_bad_cpu_reset", int'(cpu_reset), 1);
    sq = '{'hA5, 'h03, 'h11, 'h22, 'h33, 'h66};
    send(0);
    @(negedge clk);
    chk("t2_good_done", int'(load_done), 1);
    chk("t2_good_error", int'(load_error), 0);

    // Length 0 means 256 payload bytes
    w0 = wlog_addr.size();
    sq = '{'hA5, 'h00};
    for (int i = 0; i < 256; i++) sq.push_back(i);
    sq.push_back('h80);
    send(0);
    @(negedge clk);
    chk("t3_byte_count", int'(byte_count), 256);
    chk("t3_done", int'(load_done), 1);
    chk("t3_nwrites", wlog_addr.size() - w0, 256);
    chk("t3_last_addr", wlog_addr[w0 + 255], 255);
    chk("t3_mem200", int'(dut_mem[8'd200]), 200);
    chk("t3_model_mem200", int'(exp_mem[8'd200]), 200);
    check_mem("t3_mem");

    // Timeout after TIMEOUT_CYCLES idle cycles
    w0 = wlog_addr.size();
    sq = '{'hA5, 'h02, 'h10};
    send(0);
    repeat (To - 1) @(negedge clk);
    chk("t4_before_limit", int'(load_error), 0);
    @(negedge clk);
    chk("t4_timeout_error", int'(load_error), 1);
    chk("t4_cpu_reset", int'(cpu_reset), 1);
    chk("t4_nwrites", wlog_addr.size() - w0, 1);
    chk("t4_addr0_data", int'(dut_mem[8'd0]), 'h10);

    // A byte in the limit cycle is accepted
    sq = '{'hA5, 'h02, 'h10};
    send(0);
    repeat (To - 1) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h20;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t5_limit_wren", int'(pm_wren), 1);
    chk("t5_limit_addr", int'(pm_wr_addr), 1);
    chk("t5_limit_data", int'(pm_wr_data), 'h20);
    chk("t5_no_error", int'(load_error), 0);
    sq = '{'h30};
    send(0);
    @(negedge clk);
    chk("t5_done", int'(load_done), 1);

    // Reset mid-DATA, then a full frame (header-valued payload byte) from address 0
    sq = '{'hA5, 'h04, 'h01, 'h02};
    send(0);
    chk("t6_wren_before", int'(pm_wren), 1);
    #1 reset = 1'b1;
    #1;
    chk("t6_wren_cut", int'(pm_wren), 0);
    chk("t6_cpu_reset", int'(cpu_reset), 1);
    chk("t6_ready_low", int'(rx_ready), 0);
    @(negedge clk);
    reset = 1'b0;
    w0 = wlog_addr.size();
    sq = '{'h01, 'hA5, 'h04, 'h0A, 'hA5, 'h0C, 'h0D, 'hC8};
    send(0);
    @(negedge clk);
    chk("t6_done", int'(load_done), 1);
    chk("t6_nwrites", wlog_addr.size() - w0, 4);
    chk("t6_first_addr", wlog_addr[w0], 0);
    chk("t6_hdr_as_data", wlog_data[w0 + 1], 'hA5);
    check_mem("t6_mem");

    // Randomized traffic
    for (int it = 0; it < 60; it++) rand_frame();
    sq = '{'hA5, 'h02, 'h55, 'h66, 'hBB};
    send(1);
    repeat (2) @(negedge clk);
    chk("final_done", int'(load_done), 1);
    check_mem("final_mem");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
